// File: rtl/lut_neuron_loader_if.sv
// Handshake bundle for lut_neuron_loader.
//   Config side : cfg_start, cfg_valid, cfg_data -> cfg_ready, cfg_done, loaded
//   Lookup side : in_valid, in_data -> in_ready
//   Result side : out_ready -> out_valid, out_data
// The master modport drives requests (bus/fabric side); the slave modport is
// the neuron itself.
interface lut_neuron_loader_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 2,
  parameter int CFG_W = 8
);
  logic             cfg_start;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_done;
  logic             loaded;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_done, loaded, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
    output cfg_ready, cfg_done, loaded, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable truth-table neuron. A config stream fills a
// 2^IN_W x OUT_W flop table (EPW entries per CFG_W word, NWORDS words per
// load); a valid/ready lookup port then returns table[in_data] one cycle
// after acceptance through a single output register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (clears table and all control)
//   bus  - lut_neuron_loader_if.slave: config, lookup and result handshakes
module lut_neuron_loader #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 2,
  parameter int CFG_W = 8
) (
  input logic                clk,
  input logic                rst,
  lut_neuron_loader_if.slave bus
);

  localparam int DEPTH  = 1 << IN_W;
  localparam int EPW    = CFG_W / OUT_W;
  localparam int NWORDS = DEPTH * OUT_W / CFG_W;
  localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              cfg_done_q, cfg_done_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [OUT_W-1:0]  table_q [DEPTH];

  logic              wr_en;
  logic              in_acc;
  logic              cfg_ready_w;
  logic              in_ready_w;
  logic [IN_W-1:0]   wr_base;

  assign cfg_ready_w = (state_q == S_LOAD);
  // Single output register: a new lookup fits when it is empty or draining.
  assign in_ready_w  = (state_q == S_READY) && (!out_valid_q || bus.out_ready);
  assign in_acc      = bus.in_valid && in_ready_w;
  assign wr_base     = IN_W'(int'(wc_q) * EPW);

  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    cfg_done_d = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (bus.cfg_start) begin
          state_d = S_LOAD;
          wc_d    = '0;
        end
      end
      S_LOAD: begin
        // A restart outranks a word presented in the same cycle; that word
        // is dropped even though cfg_ready is high.
        if (bus.cfg_start) begin
          wc_d = '0;
        end else if (bus.cfg_valid) begin
          wr_en = 1'b1;
          if (wc_q == WC_W'(NWORDS - 1)) begin
            state_d    = S_READY;
            wc_d       = '0;
            cfg_done_d = 1'b1;
          end else begin
            wc_d = wc_q + WC_W'(1);
          end
        end
      end
      S_READY: begin
        if (bus.cfg_start) begin
          state_d = S_LOAD;
          wc_d    = '0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        wc_d    = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = table_q[bus.in_data];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      wc_q        <= '0;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Table is only ever cleared by reset; reloads overwrite in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < EPW; j++)
        table_q[wr_base + IN_W'(j)] <= bus.cfg_data[OUT_W*j +: OUT_W];
    end
  end

  assign bus.cfg_ready = cfg_ready_w;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.loaded    = (state_q == S_READY);
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
module tb_lut_neuron_loader;
  localparam int IN_W   = 6;
  localparam int OUT_W  = 2;
  localparam int CFG_W  = 8;
  localparam int DEPTH  = 1 << IN_W;
  localparam int EPW    = CFG_W / OUT_W;
  localparam int NWORDS = DEPTH * OUT_W / CFG_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_neuron_loader_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CFG_W(CFG_W)) bus_if ();

  lut_neuron_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .CFG_W(CFG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  // Reference: the neuron function as an array, load progress as a word
  // index, and the pending results as an ordered queue.
  int               m_tbl [DEPTH];
  int               m_wc;
  bit               m_loaded;
  logic [OUT_W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    m_wc     = 0;
    m_loaded = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_loaded"},    32'(bus_if.loaded),    32'd0);
    chk({tag, "_cfg_ready"}, 32'(bus_if.cfg_ready), 32'd0);
    chk({tag, "_cfg_done"},  32'(bus_if.cfg_done),  32'd0);
    chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(bus_if.out_data),  32'd0);
  endtask

  task automatic cfg_start_pulse();
    bus_if.cfg_start = 1'b1;
    bus_if.cfg_valid = 1'b0;
    @(posedge clk); #1;
    bus_if.cfg_start = 1'b0;
    m_wc     = 0;
    m_loaded = 1'b0;
    #1;
    chk("start_cfg_ready", 32'(bus_if.cfg_ready), 32'd1);
    chk("start_loaded",    32'(bus_if.loaded),    32'd0);
  endtask

  // One config cycle; with_start set means a restart collides with the word.
  task automatic cfg_word(input logic [CFG_W-1:0] w, input bit with_start);
    bit exp_done;
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_data  = w;
    bus_if.cfg_start = with_start;
    #1;
    chk("cfg_ready", 32'(bus_if.cfg_ready), 32'd1);
    exp_done = 1'b0;
    if (with_start) begin
      m_wc = 0;
    end else begin
      for (int j = 0; j < EPW; j++) m_tbl[m_wc*EPW + j] = int'(w[OUT_W*j +: OUT_W]);
      if (m_wc == NWORDS - 1) begin
        exp_done = 1'b1;
        m_wc     = 0;
      end else begin
        m_wc++;
      end
    end
    @(posedge clk); #1;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_start = 1'b0;
    if (exp_done) m_loaded = 1'b1;
    if (bus_if.cfg_done) n_done++;
    chk("cfg_done", 32'(bus_if.cfg_done), 32'(exp_done));
    chk("loaded",   32'(bus_if.loaded),   32'(m_loaded));
  endtask

  // One lookup-port cycle: check handshake and any result consumed this cycle.
  task automatic lk(input bit v, input logic [IN_W-1:0] a, input bit ordy);
    bit exp_rdy;
    bus_if.in_valid  = v;
    bus_if.in_data   = a;
    bus_if.out_ready = ordy;
    #1;
    exp_rdy = m_loaded && (exp_q.size() == 0 || ordy);
    chk("in_ready",  32'(bus_if.in_ready),  32'(exp_rdy));
    chk("out_valid", 32'(bus_if.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_data", 32'(bus_if.out_data), 32'(exp_q[0]));
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (v && exp_rdy) exp_q.push_back(OUT_W'(m_tbl[a]));
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) lk(1'b0, '0, 1'b1);
  endtask

  task automatic load_const(input logic [CFG_W-1:0] w);
    cfg_start_pulse();
    for (int i = 0; i < NWORDS; i++) cfg_word(w, 1'b0);
  endtask

  task automatic load_random();
    cfg_start_pulse();
    for (int i = 0; i < NWORDS; i++) cfg_word(CFG_W'($urandom), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.cfg_start = 1'b0;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_data  = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    model_clear();

    // Reset state and a lookup attempt while empty.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    lk(1'b1, 6'd5, 1'b1);
    lk(1'b0, '0, 1'b1);
    chk("empty_loaded", 32'(bus_if.loaded), 32'd0);
    bus_if.cfg_valid = 1'b1;
    #1;
    chk("empty_cfg_ready", 32'(bus_if.cfg_ready), 32'd0);
    bus_if.cfg_valid = 1'b0;

    // Constant table: entry a = a mod 4.
    n_done = 0;
    load_const(8'b11100100);
    chk("e4_done_count", 32'(n_done), 32'd1);
    lk(1'b1, 6'd45, 1'b1);
    chk("e4_look45", 32'(bus_if.out_data), 32'd1);
    lk(1'b1, 6'd63, 1'b1);
    chk("e4_look63", 32'(bus_if.out_data), 32'd3);
    drain();

    // Parity table, back-to-back sweep at full throughput.
    load_const(8'b11001100);
    for (int a = 0; a < DEPTH; a++) lk(1'b1, IN_W'(a), 1'b1);
    drain();

    // Backpressure: hold a result for 3 cycles with a request waiting.
    lk(1'b1, 6'd7, 1'b1);
    for (int k = 0; k < 3; k++) lk(1'b1, 6'd8, 1'b0);
    lk(1'b1, 6'd8, 1'b1);
    drain();

    // Random table and random handshake traffic.
    load_random();
    for (int k = 0; k < 400; k++)
      lk(bit'($urandom_range(0, 1)), IN_W'($urandom), bit'($urandom_range(0, 2) != 0));
    drain();

    // Reload while a result is parked: it survives until consumed.
    lk(1'b1, 6'd33, 1'b0);
    bus_if.out_ready = 1'b0;
    cfg_start_pulse();
    chk("parked_valid", 32'(bus_if.out_valid), 32'd1);
    chk("parked_data",  32'(bus_if.out_data),  32'(exp_q[0]));
    lk(1'b1, 6'd1, 1'b1);

    // Restart mid-load with a colliding word, then a full new load.
    n_done = 0;
    for (int i = 0; i < 5; i++) cfg_word(CFG_W'($urandom), 1'b0);
    cfg_word(CFG_W'($urandom), 1'b1);
    for (int i = 0; i < NWORDS; i++) cfg_word(CFG_W'($urandom), 1'b0);
    chk("restart_done_count", 32'(n_done), 32'd1);
    for (int a = 0; a < DEPTH; a++) lk(1'b1, IN_W'(a), 1'b1);
    drain();

    // Asynchronous reset mid-load, then a fresh load.
    cfg_start_pulse();
    for (int i = 0; i < 8; i++) cfg_word(CFG_W'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    model_clear();
    check_reset_outputs("midrst");
    chk("midrst_in_ready", 32'(bus_if.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    load_random();
    lk(1'b1, 6'd0, 1'b1);
    for (int a = 1; a < DEPTH; a++) lk(1'b1, IN_W'(a), bit'($urandom_range(0, 1)));
    for (int k = 0; k < 4; k++) lk(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Runtime-programmable truth-table neuron for the LogicNets inference fabric. It is the writable counterpart of the fixed ROM neurons: a configuration stream writes a 2^IN_W-entry, OUT_W-bit table, and a valid/ready lookup port then maps IN_W-bit activation codes to OUT_W-bit output codes. It sits between the configuration bus and a layer slot, so trained neuron functions can be swapped without resynthesis.

## Interface
- IN_W, 6, activation input width; table depth = 2^IN_W entries
- OUT_W, 2, output code width per entry
- CFG_W, 8, config word width; must be a multiple of OUT_W and divide 2^IN_W*OUT_W
- Derived: EPW = CFG_W/OUT_W entries per word; NWORDS = 2^IN_W*OUT_W/CFG_W (16 at defaults)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  one-cycle pulse: begin (or restart) a table load
- cfg_valid  in  1  config word valid
- cfg_data  in  CFG_W  config word
- cfg_ready  out  1  config word accepted when cfg_valid & cfg_ready
- cfg_done  out  1  one-cycle pulse: last word of a load written
- loaded  out  1  level: table holds a complete load
- in_valid  in  1  lookup request valid
- in_ready  out  1  lookup request accepted when in_valid & in_ready
- in_data  in  IN_W  activation code (table address)
- out_valid  out  1  lookup result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  looked-up output code

## Operation
- States: EMPTY (after reset), LOAD, READY.
- EMPTY: table all zeros, loaded=0, cfg_ready=0, in_ready=0. cfg_start -> LOAD.
- LOAD: cfg_ready=1, in_ready=0; word counter wc starts at 0. Each accepted word writes entries wc*EPW+j from cfg_data[OUT_W*j +: OUT_W], j=0..EPW-1; wc increments. Acceptance of word NWORDS-1 -> READY, loaded=1, cfg_done pulses.
- cfg_start during LOAD: wc resets to 0, stays in LOAD; entries already written keep their values until overwritten. cfg_start and cfg_valid in the same cycle: start wins, that word is discarded (cfg_ready reads 1 but no write occurs; counts as a restart).
- READY: in_ready = !out_valid | out_ready (single output register). Accepted lookup loads out_data = table[in_data], sets out_valid. out_valid clears on out_ready with no new accept. cfg_start -> LOAD, loaded=0; a result already in the output register stays valid until consumed; no new lookups accepted.
- cfg_valid outside LOAD: ignored, cfg_ready=0. in_valid outside READY: ignored.
- Table is flop-based (distributed), cleared by reset only; a reload never clears it.

## Timing
- Reset values: state=EMPTY, wc=0, table=0, cfg_ready=0, cfg_done=0, loaded=0, in_ready=0, out_valid=0, out_data=0.
- Lookup latency: 1 cycle (accept on edge N, out_valid/out_data valid after edge N, i.e. cycle N+1). Throughput 1 lookup/cycle with out_ready held high.
- Load: NWORDS accepted words minimum; cfg_done and loaded rise on the edge that accepts the last word; first lookup accept possible the following cycle.
- out_data is stable while out_valid & !out_ready.
- Reset mid-load or mid-lookup: immediate return to reset values; partial table content discarded (cleared).

## Test plan
- Reset then lookup attempt: in_valid=1, in_data=6'd5 -> in_ready=0, out_valid stays 0; loaded=0.
- Load 16 words of 8'b11100100, then lookup in_data=6'd45 -> cfg_done pulse on 16th accept, out_data=2'b01 one cycle after accept; in_data=6'd63 -> 2'b11.
- Load table where entry a = {2{a[0]}} (words 8'b11001100), stream in_data 0..63 back-to-back with out_ready=1 -> 64 results, out_data=2'b11 for odd a, 2'b00 for even, one per cycle.
- Backpressure: out_ready=0 for 3 cycles after a result -> out_data held, in_ready=0, no request lost; release -> next request accepted that cycle.
- Restart mid-load: 5 words, cfg_start with cfg_valid=1, then 16 new words -> final table equals the new 16 words only; cfg_done pulses exactly once.
- Assert rst after 8 words -> all outputs reset; new full load followed by lookup of entry 0 returns value from new load, any unwritten entries read 2'b00.
